alu_shift_issue: RTL

//  Operand issue stage directly upstream of the 16-bit shift/rotate ALU.
//  - Accepts {A, B, opcode} over a valid/ready handshake.
//  - Normalises the shift amount and drops illegal opcodes.
//  - Buffers operands in a 2-entry skid buffer, so in_ready is a registered

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_skid_buf.sv | 102 ++++++++++
 rtl/alu_shift_issue.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared operand type and opcode decode for the shift/rotate ALU pipeline.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OPC_SLL  = 3'b011;
  localparam logic [2:0] OPC_SAR  = 3'b100;
  localparam logic [2:0] OPC_ROTL = 3'b101;
  localparam logic [2:0] OPC_ROTR = 3'b110;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [2:0]           opcode;
  } shift_op_t;

  function automatic logic is_shift_op(input logic [2:0] opc);
    return (opc == OPC_SLL) || (opc == OPC_SAR) ||
           (opc == OPC_ROTL) || (opc == OPC_ROTR);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer: registered in_ready/out_valid, strict FIFO order,
// synchronous flush. Payload type is a parameter so other ALU stages can reuse it.
module alu_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  T       main_q, main_d;
  T       skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  a_hold_when_stalled: assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready && !flush) |=> (out_valid_q && $stable(main_q))
  );

  a_full_not_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_TWO) |-> !in_ready_q
  );

endmodule

// File: rtl/alu_shift_issue.sv
// Operand issue stage ahead of the shift/rotate ALU: normalises shift amounts,
// drops and counts illegal opcodes, and buffers legal ops in a skid buffer.
module alu_shift_issue
  import alu_pkg::*;
#(
  // Must match alu_pkg::ALU_WIDTH, which sizes the buffered shift_op_t.
  parameter int WIDTH = ALU_WIDTH,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_opcode,
  output logic             out_en,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int               SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SLL_SAT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] SAR_SAT = WIDTH'(WIDTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic             b_oversize;
  logic [WIDTH-1:0] norm_b;
  logic             legal;
  logic             accept;
  logic             drop;
  logic             buf_in_ready;
  shift_op_t        in_op;
  shift_op_t        out_op;

  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // Any bit above the shift-amount field means the amount is >= WIDTH.
  assign b_oversize = |in_b[WIDTH-1:SHAMT_W];

  always_comb begin
    norm_b = '0;
    case (in_opcode)
      OPC_SLL:            norm_b = b_oversize ? SLL_SAT : in_b;
      OPC_SAR:            norm_b = b_oversize ? SAR_SAT : in_b;
      OPC_ROTL, OPC_ROTR: norm_b = {{(WIDTH - SHAMT_W){1'b0}}, in_b[SHAMT_W-1:0]};
      default:            norm_b = '0;
    endcase
  end

  assign legal  = is_shift_op(in_opcode);
  assign accept = in_valid & buf_in_ready & ~flush;
  assign drop   = accept & ~legal;

  always_comb begin
    in_op        = '0;
    in_op.a      = in_a;
    in_op.b      = norm_b;
    in_op.opcode = in_opcode;
  end

  // Illegal ops share the ready rule but never enter the buffer.
  alu_skid_buf #(
    .T (shift_op_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid & legal),
    .in_ready  (buf_in_ready),
    .in_data   (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_op)
  );

  always_comb begin
    err_pulse_d = drop;
    err_count_d = err_count_q;
    if (drop && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready   = buf_in_ready;
  assign out_a      = out_op.a;
  assign out_b      = out_op.b;
  assign out_opcode = out_op.opcode;
  assign out_en     = out_valid;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule
